// File: rtl/hit_arbiter_controller.sv
// Round-robin hit arbiter for the lives block: grants one hazard source and holds loseLife
// until the lives block accepts it. After the hit is accepted it runs a grace window, and it freezes on gameOver.
module hit_arbiter_controller #(
    parameter int NUM_SOURCES  = 4,
    parameter int SRC_BITWIDTH = $clog2(NUM_SOURCES),
    parameter int GRACE_CYCLES = 50_000_000,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NUM_SOURCES-1:0]  hitRequest_i,
    input  logic                    livesReady_i,
    input  logic                    gameOver_i,
    output logic                    loseLife_o,
    output logic [NUM_SOURCES-1:0]  hitGrant_o,
    output logic [SRC_BITWIDTH-1:0] lastSource_o,
    output logic                    invulnerable_o,
    output logic                    halted_o,
    output logic                    ackError_o
);

    localparam int GW = $clog2(GRACE_CYCLES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [GW-1:0] GRACE_LOAD = GW'(GRACE_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
    localparam logic [SRC_BITWIDTH-1:0] SRC_LAST = SRC_BITWIDTH'(NUM_SOURCES - 1);

    typedef enum logic [1:0] {ARMED, REQUEST, GRACE, HALTED} state_t;

    state_t                  state_q;
    logic [SRC_BITWIDTH-1:0] rr_ptr_q;
    logic [SRC_BITWIDTH-1:0] rr_ptr_d;
    logic [SRC_BITWIDTH-1:0] last_source_q;
    logic [NUM_SOURCES-1:0]  hit_grant_q;
    logic [GW-1:0]           grace_count_q;
    logic [AW-1:0]           ack_count_q;
    logic                    lose_life_q;
    logic                    invulnerable_q;
    logic                    halted_q;
    logic                    ack_error_q;

    logic                    win_found;
    logic [SRC_BITWIDTH-1:0] win_idx;
    logic [NUM_SOURCES-1:0]  win_onehot;

    // Search starts at rr_ptr_q and wraps; the first set request in that order wins.
    always_comb begin
        int unsigned k;
        k         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            k = (int'(rr_ptr_q) + i) % NUM_SOURCES;
            if (!win_found && hitRequest_i[SRC_BITWIDTH'(k)]) begin
                win_found = 1'b1;
                win_idx   = SRC_BITWIDTH'(k);
            end
        end
    end

    assign rr_ptr_d = (win_idx == SRC_LAST) ? '0 : win_idx + SRC_BITWIDTH'(1);

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == SRC_BITWIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= ARMED;
            rr_ptr_q       <= '0;
            last_source_q  <= '0;
            hit_grant_q    <= '0;
            grace_count_q  <= '0;
            ack_count_q    <= '0;
            lose_life_q    <= 1'b0;
            invulnerable_q <= 1'b0;
            halted_q       <= 1'b0;
            ack_error_q    <= 1'b0;
        end else begin
            hit_grant_q <= '0;
            case (state_q)
                ARMED: begin
                    if (gameOver_i) begin
                        halted_q <= 1'b1;
                        state_q  <= HALTED;
                    end else if (win_found && livesReady_i) begin
                        hit_grant_q   <= win_onehot;
                        last_source_q <= win_idx;
                        lose_life_q   <= 1'b1;
                        rr_ptr_q      <= rr_ptr_d;
                        ack_count_q   <= '0;
                        state_q       <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (!livesReady_i) begin
                        lose_life_q    <= 1'b0;
                        invulnerable_q <= 1'b1;
                        grace_count_q  <= GRACE_LOAD;
                        state_q        <= GRACE;
                    end else if (ack_count_q == ACK_LAST) begin
                        lose_life_q <= 1'b0;
                        ack_error_q <= 1'b1;
                        state_q     <= ARMED;
                    end else begin
                        ack_count_q <= ack_count_q + AW'(1);
                    end
                end
                GRACE: begin
                    // Requests are deliberately dropped here; only still-held levels re-arm.
                    if (gameOver_i) begin
                        invulnerable_q <= 1'b0;
                        halted_q       <= 1'b1;
                        state_q        <= HALTED;
                    end else if (grace_count_q == '0) begin
                        invulnerable_q <= 1'b0;
                        state_q        <= ARMED;
                    end else begin
                        grace_count_q <= grace_count_q - GW'(1);
                    end
                end
                HALTED: begin
                    lose_life_q    <= 1'b0;
                    invulnerable_q <= 1'b0;
                    halted_q       <= 1'b1;
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign loseLife_o     = lose_life_q;
    assign hitGrant_o     = hit_grant_q;
    assign lastSource_o   = last_source_q;
    assign invulnerable_o = invulnerable_q;
    assign halted_o       = halted_q;
    assign ackError_o     = ack_error_q;

endmodule

// File: tb/tb_hit_arbiter_controller.sv
// Directed bench for hit_arbiter_controller: expected grants are queued by the stimulus and
// popped by an independent monitor whenever a grant pulse appears.
module tb_hit_arbiter_controller;

    localparam int N  = 4;
    localparam int SB = 2;
    localparam int G  = 8;
    localparam int A  = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [N-1:0]  hitRequest_i = '0;
    logic          livesReady_i = 1'b1;
    logic          gameOver_i = 1'b0;
    logic          loseLife_o;
    logic [N-1:0]  hitGrant_o;
    logic [SB-1:0] lastSource_o;
    logic          invulnerable_o;
    logic          halted_o;
    logic          ackError_o;

    hit_arbiter_controller #(
        .NUM_SOURCES (N),
        .SRC_BITWIDTH(SB),
        .GRACE_CYCLES(G),
        .ACK_TIMEOUT (A)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .hitRequest_i  (hitRequest_i),
        .livesReady_i  (livesReady_i),
        .gameOver_i    (gameOver_i),
        .loseLife_o    (loseLife_o),
        .hitGrant_o    (hitGrant_o),
        .lastSource_o  (lastSource_o),
        .invulnerable_o(invulnerable_o),
        .halted_o      (halted_o),
        .ackError_o    (ackError_o)
    );

    always #5 clock_i = ~clock_i;

    int         checks = 0;
    int         failures = 0;
    logic [5:0] exp_q[$];
    logic       auto_ack = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    // Monitor: every grant pulse must match the next queued {onehot, index}.
    always @(negedge clock_i) begin
        if (!reset_i && hitGrant_o != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", int'(hitGrant_o), 0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("grant", int'({hitGrant_o, lastSource_o}), int'(e));
            end
        end
    end

    // Lives model: accepts loseLife on the cycle after it appears.
    always @(negedge clock_i) begin
        if (auto_ack) livesReady_i = !loseLife_o;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_i);
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (hitGrant_o != '0) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: got no grant expected one within 20 cycles");
        end
    endtask

    task automatic count_high(input bit sel_lose, output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!(sel_lose ? loseLife_o : invulnerable_o)) break;
            n++;
            cyc(1);
        end
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        auto_ack     = 1'b0;
        hitRequest_i = '0;
        gameOver_i   = 1'b0;
        livesReady_i = 1'b1;
        cyc(1);
        check("reset_outputs", int'({loseLife_o, hitGrant_o, lastSource_o,
                                     invulnerable_o, halted_o, ackError_o}), 0);
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int seen;

        // 1: single request, manual acknowledge, grace length
        cyc(1);
        do_reset();
        hitRequest_i = 4'b0100;
        exp_q.push_back({4'b0100, 2'd2});
        wait_grant(lat);
        check("t1_latency", lat, 1);
        hitRequest_i = '0;
        check("t1_loselife_on", int'(loseLife_o), 1);
        cyc(1);
        check("t1_held_no_grant", int'({loseLife_o, hitGrant_o}), 16);
        livesReady_i = 1'b0;
        cyc(1);
        livesReady_i = 1'b1;
        check("t1_loselife_off", int'(loseLife_o), 0);
        count_high(1'b0, n);
        check("t1_grace_len", n, G);

        // 2: all sources held, round-robin order with grace between grants
        do_reset();
        auto_ack = 1'b1;
        hitRequest_i = 4'b1111;
        exp_q.push_back({4'b0001, 2'd0});
        exp_q.push_back({4'b0010, 2'd1});
        exp_q.push_back({4'b0100, 2'd2});
        exp_q.push_back({4'b1000, 2'd3});
        exp_q.push_back({4'b0001, 2'd0});
        for (int k = 0; k < 5; k++) begin
            wait_grant(lat);
            cyc(1);
            count_high(1'b0, n);
            check("t2_grace_len", n, G);
            if (k == 4) hitRequest_i = '0;
        end

        // 3: request pulse only during grace is ignored
        hitRequest_i = 4'b1000;
        exp_q.push_back({4'b1000, 2'd3});
        wait_grant(lat);
        hitRequest_i = '0;
        seen = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc(1);
            if (i == 2) hitRequest_i = 4'b0010;
            if (i == 3) check("t3_in_grace", int'(invulnerable_o), 1);
            if (i == 5) hitRequest_i = '0;
            if (loseLife_o || hitGrant_o != '0) seen = 1;
        end
        check("t3_no_grant", seen, 0);

        // 4: acknowledge timeout
        auto_ack = 1'b0;
        livesReady_i = 1'b1;
        hitRequest_i = 4'b0001;
        exp_q.push_back({4'b0001, 2'd0});
        wait_grant(lat);
        hitRequest_i = '0;
        count_high(1'b1, n);
        check("t4_loselife_len", n, A);
        check("t4_ackerror_noinv", int'({ackError_o, invulnerable_o}), 2);
        hitRequest_i = 4'b0100;
        exp_q.push_back({4'b0100, 2'd2});
        wait_grant(lat);
        check("t4_armed_latency", lat, 1);
        hitRequest_i = '0;
        cyc(6);
        check("t4_ackerror_sticky", int'(ackError_o), 1);

        // 5: gameOver beats a same-cycle request; gameOver during grace
        do_reset();
        gameOver_i = 1'b1;
        hitRequest_i = 4'b0001;
        cyc(1);
        check("t5_halted", int'(halted_o), 1);
        check("t5_no_grant", int'({loseLife_o, hitGrant_o}), 0);
        gameOver_i = 1'b0;
        hitRequest_i = '0;
        cyc(2);
        check("t5_halted_sticky", int'(halted_o), 1);
        do_reset();
        auto_ack = 1'b1;
        hitRequest_i = 4'b0010;
        exp_q.push_back({4'b0010, 2'd1});
        wait_grant(lat);
        hitRequest_i = '0;
        cyc(3);
        check("t5_grace_inv", int'(invulnerable_o), 1);
        gameOver_i = 1'b1;
        cyc(1);
        check("t5_grace_halt", int'({halted_o, invulnerable_o}), 2);
        gameOver_i = 1'b0;

        // 6: asynchronous reset in the middle of grace
        do_reset();
        auto_ack = 1'b1;
        hitRequest_i = 4'b0100;
        exp_q.push_back({4'b0100, 2'd2});
        wait_grant(lat);
        hitRequest_i = '0;
        cyc(4);
        check("t6_grace_inv", int'(invulnerable_o), 1);
        #2 reset_i = 1'b1;
        #1 check("t6_async_reset", int'({loseLife_o, hitGrant_o, lastSource_o,
                                          invulnerable_o, halted_o, ackError_o}), 0);
        cyc(1);
        reset_i = 1'b0;
        hitRequest_i = 4'b1111;
        exp_q.push_back({4'b0001, 2'd0});
        wait_grant(lat);
        hitRequest_i = '0;
        cyc(15);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
